scoreboard_hazard: RTL and testbench

SCOREBOARD_HAZARD -- requirements
Module: scoreboard_hazard

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_use_detect.sv | 25 ++
 rtl/scoreboard_hazard.sv | 110 +++++++++++
 tb/tb_scoreboard_hazard.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file geometry and scoreboard defaults.
// Imported by the hazard unit and its comparator.
package riscv_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 32;
    localparam int MAX_LOP_DEF = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    function automatic reg_vec_t reg_onehot(input reg_addr_t a);
        reg_vec_t v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: ID source matches the destination of a load in EX.
// x0 never creates a dependence.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic                  MemRead_ex,
    input  logic [REG_ADDR_W-1:0] rdAddr_ex,
    input  logic                  rs1Used_id,
    input  logic [REG_ADDR_W-1:0] rs1Addr_id,
    input  logic                  rs2Used_id,
    input  logic [REG_ADDR_W-1:0] rs2Addr_id,
    output logic                  load_use
);

    logic hit1;
    logic hit2;

    assign hit1 = rs1Used_id && (rs1Addr_id == rdAddr_ex);
    assign hit2 = rs2Used_id && (rs2Addr_id == rdAddr_ex);

    assign load_use = MemRead_ex
                   && (rdAddr_ex != '0)
                   && (hit1 || hit2);

endmodule

// File: rtl/scoreboard_hazard.sv
// ID-stage hazard unit: load-use interlock plus a busy-bit scoreboard
// tracking outstanding long-latency (MDU) writes.
module scoreboard_hazard
    import riscv_pkg::*;
#(
    parameter int MAX_LOP = MAX_LOP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_id,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1Addr_id,
    input  logic [REG_ADDR_W-1:0] rs2Addr_id,
    input  logic                  rs1Used_id,
    input  logic                  rs2Used_id,
    input  logic                  RegWrite_id,
    input  logic [REG_ADDR_W-1:0] rdAddr_id,
    input  logic                  LongOp_id,
    input  logic                  MemRead_ex,
    input  logic [REG_ADDR_W-1:0] rdAddr_ex,
    input  logic                  lwb_valid,
    input  logic [REG_ADDR_W-1:0] lwb_rdAddr,
    output logic                  stall_id,
    output logic                  issue_id,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [1:0]            lop_count,
    output logic                  sb_err
);

    reg_vec_t   busy_q, busy_d;
    logic [1:0] lop_q, lop_d;
    logic       err_q, err_d;

    logic load_use;
    logic raw_busy;
    logic waw_busy;
    logic struct_full;
    logic live;
    logic lop_inc;
    logic set_en;
    logic clr_en;
    logic lwb_bad;

    load_use_detect u_lud (
        .MemRead_ex (MemRead_ex),
        .rdAddr_ex  (rdAddr_ex),
        .rs1Used_id (rs1Used_id),
        .rs1Addr_id (rs1Addr_id),
        .rs2Used_id (rs2Used_id),
        .rs2Addr_id (rs2Addr_id),
        .load_use   (load_use)
    );

    // Hazards look only at registered state: no writeback bypass.
    assign raw_busy = (rs1Used_id && busy_q[rs1Addr_id])
                   || (rs2Used_id && busy_q[rs2Addr_id]);
    assign waw_busy = RegWrite_id && busy_q[rdAddr_id];
    assign struct_full = LongOp_id && (lop_q == 2'(MAX_LOP));

    assign live = rst_n && valid_id && !flush;
    assign stall_id = live
                   && (load_use || raw_busy || waw_busy || struct_full);
    assign issue_id = live && !stall_id;

    assign lop_inc = issue_id && LongOp_id;
    assign set_en = lop_inc && RegWrite_id && (rdAddr_id != '0);
    assign clr_en = lwb_valid && (lwb_rdAddr != '0);

    // x0 writebacks are legal returns of long ops that targeted x0.
    assign lwb_bad = lwb_valid
                  && ((lop_q == 2'd0)
                   || ((lwb_rdAddr != '0) && !busy_q[lwb_rdAddr]));

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~reg_onehot(lwb_rdAddr);
        end
        if (set_en) begin
            busy_d = busy_d | reg_onehot(rdAddr_id);
        end
        busy_d[0] = 1'b0;

        lop_d = lop_q;
        if (lop_inc && !lwb_valid) begin
            lop_d = lop_q + 2'd1;
        end else if (!lop_inc && lwb_valid && (lop_q != 2'd0)) begin
            lop_d = lop_q - 2'd1;
        end

        err_d = err_q || lwb_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            lop_q  <= 2'd0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            lop_q  <= lop_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec  = busy_q;
    assign lop_count = lop_q;
    assign sb_err    = err_q;

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Scoreboard bench for scoreboard_hazard: directed scenarios then
// randomized traffic, checked against a set-of-pending-registers model.
module tb_scoreboard_hazard;

    localparam int MAXL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_id = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1Addr_id = '0;
    logic [4:0]  rs2Addr_id = '0;
    logic        rs1Used_id = 1'b0;
    logic        rs2Used_id = 1'b0;
    logic        RegWrite_id = 1'b0;
    logic [4:0]  rdAddr_id = '0;
    logic        LongOp_id = 1'b0;
    logic        MemRead_ex = 1'b0;
    logic [4:0]  rdAddr_ex = '0;
    logic        lwb_valid = 1'b0;
    logic [4:0]  lwb_rdAddr = '0;
    logic        stall_id;
    logic        issue_id;
    logic [31:0] busy_vec;
    logic [1:0]  lop_count;
    logic        sb_err;

    scoreboard_hazard #(.MAX_LOP(MAXL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_id    (valid_id),
        .flush       (flush),
        .rs1Addr_id  (rs1Addr_id),
        .rs2Addr_id  (rs2Addr_id),
        .rs1Used_id  (rs1Used_id),
        .rs2Used_id  (rs2Used_id),
        .RegWrite_id (RegWrite_id),
        .rdAddr_id   (rdAddr_id),
        .LongOp_id   (LongOp_id),
        .MemRead_ex  (MemRead_ex),
        .rdAddr_ex   (rdAddr_ex),
        .lwb_valid   (lwb_valid),
        .lwb_rdAddr  (lwb_rdAddr),
        .stall_id    (stall_id),
        .issue_id    (issue_id),
        .busy_vec    (busy_vec),
        .lop_count   (lop_count),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rstn;
        bit       v;
        bit       fl;
        bit       u1;
        bit [4:0] r1;
        bit       u2;
        bit [4:0] r2;
        bit       rw;
        bit [4:0] rd;
        bit       lop;
        bit       mr;
        bit [4:0] rdex;
        bit       lwbv;
        bit [4:0] lwba;
    } stim_t;

    typedef struct {
        bit          st;
        bit          is;
        logic [31:0] bv;
        int          lops;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: which registers await a long writeback.
    bit mbusy[32];
    int mlops = 0;
    bit merr = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rstn: 1'b1, default: '0};
        return s;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit lu, raw, waw, sf, live, ok;
        @(posedge clk);
        #1;
        rst_n = s.rstn;
        valid_id = s.v;
        flush = s.fl;
        rs1Used_id = s.u1;
        rs1Addr_id = s.r1;
        rs2Used_id = s.u2;
        rs2Addr_id = s.r2;
        RegWrite_id = s.rw;
        rdAddr_id = s.rd;
        LongOp_id = s.lop;
        MemRead_ex = s.mr;
        rdAddr_ex = s.rdex;
        lwb_valid = s.lwbv;
        lwb_rdAddr = s.lwba;

        lu = s.mr && s.rdex != 0
          && ((s.u1 && s.r1 == s.rdex) || (s.u2 && s.r2 == s.rdex));
        raw = (s.u1 && s.r1 != 0 && mbusy[s.r1])
           || (s.u2 && s.r2 != 0 && mbusy[s.r2]);
        waw = s.rw && s.rd != 0 && mbusy[s.rd];
        sf = s.lop && mlops == MAXL;
        live = s.rstn && s.v && !s.fl;
        e.st = live && (lu || raw || waw || sf);
        e.is = live && !e.st;
        e.bv = pend_vec();
        e.lops = mlops;
        e.err = merr;
        exp_q.push_back(e);

        if (!s.rstn) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mlops = 0;
            merr = 1'b0;
        end else begin
            ok = e.is && s.lop;
            if (s.lwbv && (mlops == 0 || (s.lwba != 0 && !mbusy[s.lwba])))
                merr = 1'b1;
            if (s.lwbv) mbusy[s.lwba] = 1'b0;
            if (ok && s.rw && s.rd != 0) mbusy[s.rd] = 1'b1;
            if (ok && !s.lwbv) mlops++;
            else if (!ok && s.lwbv && mlops > 0) mlops--;
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_id", int'(stall_id), int'(e.st));
                chk("issue_id", int'(issue_id), int'(e.is));
                chk("busy_vec", int'(busy_vec), int'(e.bv));
                chk("lop_count", int'(lop_count), e.lops);
                chk("sb_err", int'(sb_err), int'(e.err));
            end
        end
    end

    function automatic stim_t long_op(input bit [4:0] rd);
        stim_t s;
        s = idle();
        s.v = 1'b1;
        s.lop = 1'b1;
        s.rw = 1'b1;
        s.rd = rd;
        return s;
    endfunction

    function automatic stim_t reader(input bit [4:0] r);
        stim_t s;
        s = idle();
        s.v = 1'b1;
        s.u1 = 1'b1;
        s.r1 = r;
        s.rw = 1'b1;
        s.rd = 5'd20;
        return s;
    endfunction

    function automatic stim_t with_lwb(input stim_t b, input bit [4:0] a);
        stim_t s;
        s = b;
        s.lwbv = 1'b1;
        s.lwba = a;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        int bl[$];
        s = idle();
        s.v = $urandom_range(0, 9) < 8;
        s.fl = $urandom_range(0, 9) == 0;
        s.u1 = 1'($urandom_range(0, 1));
        s.r1 = 5'($urandom_range(0, 7));
        s.u2 = 1'($urandom_range(0, 1));
        s.r2 = 5'($urandom_range(0, 7));
        s.lop = $urandom_range(0, 3) == 0;
        s.rw = s.lop ? 1'b1 : 1'($urandom_range(0, 1));
        s.rd = s.lop ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
        s.mr = $urandom_range(0, 2) == 0;
        s.rdex = 5'($urandom_range(0, 7));
        for (int i = 1; i < 32; i++) if (mbusy[i]) bl.push_back(i);
        if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
            s.lwbv = 1'b1;
            s.lwba = 5'(bl[$urandom_range(0, bl.size() - 1)]);
        end else if ($urandom_range(0, 99) == 0) begin
            s.lwbv = 1'b1;
            s.lwba = 5'($urandom_range(1, 31));
        end
        s.rstn = $urandom_range(0, 149) != 0;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = idle();
        s.rstn = 1'b0;
        repeat (2) apply(s);

        // load-use, then same pattern with rdAddr_ex=0
        s = reader(5'd5);
        s.mr = 1'b1;
        s.rdex = 5'd5;
        apply(s);
        s.rdex = 5'd0;
        apply(s);

        // RAW on a long op to x7, released the cycle after writeback
        apply(long_op(5'd7));
        repeat (3) apply(reader(5'd7));
        apply(with_lwb(reader(5'd7), 5'd7));
        apply(reader(5'd7));
        apply(idle());

        // structural limit with simultaneous writeback
        apply(long_op(5'd3));
        apply(long_op(5'd4));
        apply(long_op(5'd5));
        apply(with_lwb(long_op(5'd5), 5'd3));
        apply(long_op(5'd5));
        apply(with_lwb(idle(), 5'd4));
        apply(with_lwb(idle(), 5'd5));

        // flush beats a dependence and sets nothing
        apply(long_op(5'd6));
        s = reader(5'd6);
        s.fl = 1'b1;
        apply(s);
        s = long_op(5'd8);
        s.fl = 1'b1;
        apply(s);
        apply(with_lwb(idle(), 5'd6));
        apply(idle());

        // spurious writeback, sticky error, long op to x0
        apply(with_lwb(idle(), 5'd9));
        apply(idle());
        apply(long_op(5'd0));
        apply(idle());

        // reset with ops outstanding, then a late writeback
        s = idle();
        s.rstn = 1'b0;
        apply(s);
        apply(long_op(5'd10));
        apply(long_op(5'd11));
        s = idle();
        s.rstn = 1'b0;
        apply(s);
        apply(idle());
        apply(with_lwb(idle(), 5'd10));
        apply(idle());
        s = idle();
        s.rstn = 1'b0;
        apply(s);

        for (int i = 0; i < 3000; i++) apply(rnd());
        apply(idle());

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
